fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Issue/sequencing controller for the FPU. It accepts one 32-bit MIPS-style instruction at a time, decodes it, and executes LUI/ORI locally against an internal 32x32 register file. Arithmetic and conversion ops are issued to one of 16 external functional units (adders, multipliers, converters) over an en/complete handshake. Results are written back to the register file, and a completion or error pulse is reported to the front end.

Parameters:
TIMEOUT, 1023, max cycles to wait for unit_complete (used only with the optional feature)
NUM_UNITS, 16, number of functional units; fixed at 16

Ports:
clk  in  1  clock
rst  in  1  reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instruction  in  32  [31:26] opcode, [25:21] fmt/rs, [20:16] ft/rt, [15:11] fs, [10:6] fd, [5:0] op, [15:0] imm
unit_en  out  16  one-hot enable for the active unit
unit_a  out  64  operand A
unit_b  out  64  operand B
unit_complete  in  16  per-unit done flags
unit_z  in  64  result of the selected unit (externally muxed by the unit_en index); 32-bit results in [31:0]
out_32  out  32  last 32-bit result
out_64  out  64  last 64-bit result
complete  out  1  one-cycle pulse: instruction retired
wrong  out  1  one-cycle pulse: instruction rejected or timed out

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - all registers 0; register file cleared to 0; state IDLE.
  - unit_en, unit_a, unit_b, out_32, out_64, complete, wrong all 0.
  - instr_ready = 0 while rst is high.
- States: IDLE, EXEC.
- instr_ready = (state==IDLE) && !rst.
- Acceptance = instr_valid && instr_ready, sampled at a clk edge.
- Opcodes: ARITH=6'h11, LUI=6'h0F, ORI=6'h0D. Formats: SINGLE=5'h10, DOUBLE=5'h01.
- LUI, on acceptance:
  - R[rt] <= {imm,16'h0}.
  - Next cycle: complete=1, out_32 = written value. Stays IDLE.
- ORI, on acceptance:
  - R[rt] <= R[rs] | {16'h0,imm}.
  - Same timing as LUI.
  - A back-to-back instruction reads the new value; there is no hardwired zero register.
- Double register pair: D(n) = {R[n], R[(n+16) mod 32]}. 5-bit wrap, so n=20 pairs with R[4].
- Unit index map (op code -> unit):
  - 0 ADD.S, 1 ADD.D, 2 SUB.S, 3 SUB.D, 4 MUL.S, 5 MUL.D
  - 6 DTOF, 7 DTOSINT, 8 DTOUNSINT
  - 9 FTOD, 10 FTOSINT, 11 FTOUNSINT
  - 12 SINTTOD, 13 SINTTOF, 14 UNSINTTOD, 15 UNSINTTOF
  - ADD/SUB/MUL: op codes 0/1/2; unit chosen by format.
  - Conversions: op codes 3..12 map to units 6..15; format is ignored.
- ARITH, on acceptance:
  - Latch the decode.
  - Operands:
    - single: unit_a = {32'h0, R[ft]}, unit_b = {32'h0, R[fs]}.
    - double: unit_a = D(ft), unit_b = D(fs).
    - conversions: unit_a = R[fs] zero-extended, or D(fs) for double-source ops; unit_b = 0.
  - SUB inverts the sign bit of unit_b (bit 31 single, bit 63 double).
  - Set unit_en one-hot; go to EXEC.
  - unit_en first high in the cycle after acceptance.
- EXEC:
  - unit_en and operands are held stable.
  - Only unit_complete[selected] is honoured; other complete bits are ignored.
  - On the edge where it is sampled high:
    - capture unit_z; clear unit_en; return to IDLE.
    - assert complete=1 for the next cycle.
  - Writeback, 32-bit result: R[fd] = z[31:0], out_32 = z[31:0].
  - Writeback, 64-bit result (units 1, 3, 5, 9, 12, 14): R[fd] = z[63:32], R[(fd+16) mod 32] = z[31:0], out_64 = z.
  - Minimum ARITH latency: acceptance + unit latency + 1 cycle.
- Rejection (no state or register-file change):
  - Cases: unknown opcode; unknown op; ADD/SUB/MUL with a format other than SINGLE/DOUBLE.
  - Next cycle: wrong=1. Stays IDLE.
  - out_32/out_64 retain their previous values.
- complete and wrong are never high together.
- instr_valid while in EXEC is ignored (not accepted).

Optional Feature:
- Macro: FPU_CTRL_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to EXEC and increments every EXEC cycle.
  - If it reaches TIMEOUT without the selected complete: unit_en cleared, no writeback, wrong=1 for one cycle, return to IDLE.
- Undefined: no counter; EXEC waits indefinitely.

Decomposition:
- Shared package fpu_ctrl_pkg holds:
  - opcode, op and format constants;
  - unit index constants UNIT_ADD_S .. UNIT_UNSINTTOF;
  - state enum;
  - a per-unit "64-bit result" mask and "double source" mask.
- One sub-module, fpu_op_decode: combinational decode of instruction to unit index, valid, sub flag, double-source and double-result flags.

Test Plan:
- LUI R1,0x3F80; LUI R2,0x4000; ADD.S fd=3 ft=1 fs=2; stub unit0 completes after 3 cycles with 0x40400000
  -> unit_en=16'h0001 held 3 cycles, unit_a=0x3F800000, unit_b=0x40000000, complete pulse, out_32=0x40400000.
- SUB.S ft=1 fs=2
  -> unit_en=16'h0004, unit_b[31:0]=0xC0000000.
- LUI R20,0x4000; ADD.D ft=20 fs=20 fd=21
  -> unit_a={R20,R4}; stub z=0x4010_0000_0000_0001 writes R21=0x40100000 and R5=0x00000001; out_64 matches.
- ARITH with format 5'h05, op ADD; then opcode 6'h3F
  -> wrong pulses one cycle each, unit_en stays 0, instr_ready high the following cycle.
- Assert rst mid-EXEC, with unit_complete raised on the same edge
  -> unit_en=0, no writeback, registers 0, complete=0 the next cycle.
- FPU_CTRL_TIMEOUT_EN with TIMEOUT=8, unit never completes
  -> wrong pulse on cycle 9 of EXEC, then IDLE; without the macro, still waiting after 100 cycles.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// Shared constants and types for the FPU issue controller and its decoder.
package fpu_ctrl_pkg;

    localparam logic [5:0] OPC_ARITH = 6'h11;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_ORI   = 6'h0D;

    localparam logic [4:0] FMT_SINGLE = 5'h10;
    localparam logic [4:0] FMT_DOUBLE = 5'h01;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_MUL    = 6'd2;
    localparam logic [5:0] OP_CVT_LO = 6'd3;
    localparam logic [5:0] OP_CVT_HI = 6'd12;

    localparam logic [3:0] UNIT_ADD_S      = 4'd0;
    localparam logic [3:0] UNIT_ADD_D      = 4'd1;
    localparam logic [3:0] UNIT_SUB_S      = 4'd2;
    localparam logic [3:0] UNIT_SUB_D      = 4'd3;
    localparam logic [3:0] UNIT_MUL_S      = 4'd4;
    localparam logic [3:0] UNIT_MUL_D      = 4'd5;
    localparam logic [3:0] UNIT_DTOF       = 4'd6;
    localparam logic [3:0] UNIT_DTOSINT    = 4'd7;
    localparam logic [3:0] UNIT_DTOUNSINT  = 4'd8;
    localparam logic [3:0] UNIT_FTOD       = 4'd9;
    localparam logic [3:0] UNIT_FTOSINT    = 4'd10;
    localparam logic [3:0] UNIT_FTOUNSINT  = 4'd11;
    localparam logic [3:0] UNIT_SINTTOD    = 4'd12;
    localparam logic [3:0] UNIT_SINTTOF    = 4'd13;
    localparam logic [3:0] UNIT_UNSINTTOD  = 4'd14;
    localparam logic [3:0] UNIT_UNSINTTOF  = 4'd15;

    // Units producing a 64-bit result: ADD.D, SUB.D, MUL.D, FTOD, SINTTOD, UNSINTTOD.
    localparam logic [15:0] UNIT_RES64_MASK = 16'h522A;
    // Units consuming a register pair: ADD.D, SUB.D, MUL.D, DTOF, DTOSINT, DTOUNSINT.
    localparam logic [15:0] UNIT_DSRC_MASK  = 16'h01EA;

    typedef enum logic {
        StIdle,
        StExec
    } state_t;

    // Partner register of a double pair; 5-bit wrap is intended.
    function automatic logic [4:0] pair_reg(input logic [4:0] n);
        return n + 5'd16;
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational decode of an FPU instruction into unit index and operand/result shape.
module fpu_op_decode
    import fpu_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_fmt,
    input  logic [5:0] i_op,
    output logic       o_is_lui,
    output logic       o_is_ori,
    output logic       o_arith_ok,
    output logic [3:0] o_unit,
    output logic       o_is_sub,
    output logic       o_dbl_src,
    output logic       o_dbl_res
);

    logic w_fmt_single;
    logic w_fmt_double;

    assign o_is_lui     = (i_opcode == OPC_LUI);
    assign o_is_ori     = (i_opcode == OPC_ORI);
    assign w_fmt_single = (i_fmt == FMT_SINGLE);
    assign w_fmt_double = (i_fmt == FMT_DOUBLE);

    always_comb begin
        o_arith_ok = 1'b0;
        o_unit     = UNIT_ADD_S;
        o_is_sub   = 1'b0;
        if (i_opcode == OPC_ARITH) begin
            if (i_op <= OP_MUL) begin
                // Single/double variants sit on adjacent even/odd unit slots.
                o_arith_ok = w_fmt_single || w_fmt_double;
                o_unit     = {i_op[1:0], w_fmt_double};
                o_is_sub   = (i_op == OP_SUB);
            end else if (i_op <= OP_CVT_HI) begin
                o_arith_ok = 1'b1;
                o_unit     = i_op[3:0] + (UNIT_DTOF - OP_CVT_LO[3:0]);
            end
        end
    end

    assign o_dbl_src = UNIT_DSRC_MASK[o_unit];
    assign o_dbl_res = UNIT_RES64_MASK[o_unit];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: runs LUI/ORI locally, dispatches FP ops to external units.
// Optional macro FPU_CTRL_TIMEOUT_EN bounds the EXEC wait to TIMEOUT cycles.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 16,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [31:0]          instruction,
    output logic [NUM_UNITS-1:0] unit_en,
    output logic [63:0]          unit_a,
    output logic [63:0]          unit_b,
    input  logic [NUM_UNITS-1:0] unit_complete,
    input  logic [63:0]          unit_z,
    output logic [31:0]          out_32,
    output logic [63:0]          out_64,
    output logic                 complete,
    output logic                 wrong
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_fs;
    logic [4:0]  w_fd;
    logic [15:0] w_imm;

    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_fs     = instruction[15:11];
    assign w_fd     = instruction[10:6];
    assign w_op     = instruction[5:0];
    assign w_imm    = instruction[15:0];

    logic       w_is_lui;
    logic       w_is_ori;
    logic       w_arith_ok;
    logic [3:0] w_unit;
    logic       w_is_sub;
    logic       w_dbl_src;
    logic       w_dbl_res;

    fpu_op_decode u_decode (
        .i_opcode   (w_opcode),
        .i_fmt      (w_rs),
        .i_op       (w_op),
        .o_is_lui   (w_is_lui),
        .o_is_ori   (w_is_ori),
        .o_arith_ok (w_arith_ok),
        .o_unit     (w_unit),
        .o_is_sub   (w_is_sub),
        .o_dbl_src  (w_dbl_src),
        .o_dbl_res  (w_dbl_res)
    );

    logic [31:0]          r_rf [32];
    state_t               r_state;
    state_t               w_state_d;
    logic [NUM_UNITS-1:0] r_unit_en;
    logic [63:0]          r_unit_a;
    logic [63:0]          r_unit_b;
    logic [3:0]           r_unit_idx;
    logic [4:0]           r_fd;
    logic                 r_dbl_res;
    logic [31:0]          r_out_32;
    logic [63:0]          r_out_64;
    logic                 r_complete;
    logic                 r_wrong;

    logic        w_accept;
    logic        w_unit_done;
    logic        w_timeout;
    logic [31:0] w_lui_val;
    logic [31:0] w_ori_val;
    logic [63:0] w_d_ft;
    logic [63:0] w_d_fs;
    logic [63:0] w_op_a;
    logic [63:0] w_op_b;

    assign instr_ready = (r_state == StIdle) && !rst;
    assign w_accept    = instr_valid && instr_ready;
    assign w_unit_done = (r_state == StExec) && unit_complete[r_unit_idx];
    assign w_lui_val   = {w_imm, 16'h0};
    assign w_ori_val   = r_rf[w_rs] | {16'h0, w_imm};

`ifdef FPU_CTRL_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    assign w_timeout = (r_state == StExec) && !w_unit_done && (r_cnt == CntLast);

    always_ff @(posedge clk) begin
        if (rst || (r_state != StExec)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Operand formation; conversions take their single source from fs.
    always_comb begin
        w_d_ft = {r_rf[w_rt], r_rf[pair_reg(w_rt)]};
        w_d_fs = {r_rf[w_fs], r_rf[pair_reg(w_fs)]};
        w_op_a = 64'h0;
        w_op_b = 64'h0;
        if (w_unit <= UNIT_MUL_D) begin
            w_op_a = w_dbl_src ? w_d_ft : {32'h0, r_rf[w_rt]};
            w_op_b = w_dbl_src ? w_d_fs : {32'h0, r_rf[w_fs]};
            if (w_is_sub) begin
                if (w_dbl_src) begin
                    w_op_b[63] = ~w_op_b[63];
                end else begin
                    w_op_b[31] = ~w_op_b[31];
                end
            end
        end else begin
            w_op_a = w_dbl_src ? w_d_fs : {32'h0, r_rf[w_fs]};
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept && w_arith_ok) begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (w_unit_done || w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_unit_en  <= '0;
            r_unit_a   <= 64'h0;
            r_unit_b   <= 64'h0;
            r_unit_idx <= 4'h0;
            r_fd       <= 5'h0;
            r_dbl_res  <= 1'b0;
            r_out_32   <= 32'h0;
            r_out_64   <= 64'h0;
            r_complete <= 1'b0;
            r_wrong    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else begin
            r_state    <= w_state_d;
            r_complete <= 1'b0;
            r_wrong    <= 1'b0;
            if (w_accept) begin
                if (w_is_lui) begin
                    r_rf[w_rt] <= w_lui_val;
                    r_out_32   <= w_lui_val;
                    r_complete <= 1'b1;
                end else if (w_is_ori) begin
                    r_rf[w_rt] <= w_ori_val;
                    r_out_32   <= w_ori_val;
                    r_complete <= 1'b1;
                end else if (w_arith_ok) begin
                    r_unit_en  <= NUM_UNITS'(1) << w_unit;
                    r_unit_a   <= w_op_a;
                    r_unit_b   <= w_op_b;
                    r_unit_idx <= w_unit;
                    r_fd       <= w_fd;
                    r_dbl_res  <= w_dbl_res;
                end else begin
                    r_wrong <= 1'b1;
                end
            end
            if (w_unit_done) begin
                r_unit_en  <= '0;
                r_complete <= 1'b1;
                if (r_dbl_res) begin
                    r_rf[r_fd]           <= unit_z[63:32];
                    r_rf[pair_reg(r_fd)] <= unit_z[31:0];
                    r_out_64             <= unit_z;
                end else begin
                    r_rf[r_fd] <= unit_z[31:0];
                    r_out_32   <= unit_z[31:0];
                end
            end else if (w_timeout) begin
                r_unit_en <= '0;
                r_wrong   <= 1'b1;
            end
        end
    end

    assign unit_en  = r_unit_en;
    assign unit_a   = r_unit_a;
    assign unit_b   = r_unit_b;
    assign out_32   = r_out_32;
    assign out_64   = r_out_64;
    assign complete = r_complete;
    assign wrong    = r_wrong;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [15:0] unit_en;
    logic [63:0] unit_a;
    logic [63:0] unit_b;
    logic [15:0] unit_complete;
    logic [63:0] unit_z;
    logic [31:0] out_32;
    logic [63:0] out_64;
    logic        complete;
    logic        wrong;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_issue_ctrl #(
        .TIMEOUT (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .unit_en       (unit_en),
        .unit_a        (unit_a),
        .unit_b        (unit_b),
        .unit_complete (unit_complete),
        .unit_z        (unit_z),
        .out_32        (out_32),
        .out_64        (out_64),
        .complete      (complete),
        .wrong         (wrong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_lui(input logic [4:0] rt, input logic [15:0] imm);
        return {6'h0F, 5'd0, rt, imm};
    endfunction

    function automatic logic [31:0] enc_ori(input logic [4:0] rt, input logic [4:0] rs,
                                            input logic [15:0] imm);
        return {6'h0D, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_ar(input logic [4:0] fmt, input logic [4:0] ft,
                                           input logic [4:0] fs, input logic [4:0] fd,
                                           input logic [5:0] op);
        return {6'h11, fmt, ft, fs, fd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for exactly one edge; returns in the cycle after that edge.
    task automatic issue(input logic [31:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instruction = 32'h0;
        unit_complete = 16'h0; unit_z = 64'h0;
        tick(); tick();
        n_tests++; if (instr_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready_in_rst: got %b want 0", instr_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (unit_en !== 16'h0) begin n_fail++;
            $display("FAIL reset_unit_en: got %h want 0", unit_en); end
        n_tests++; if (unit_a !== 64'h0 || unit_b !== 64'h0) begin n_fail++;
            $display("FAIL reset_operands: got %h/%h want 0/0", unit_a, unit_b); end
        n_tests++; if (out_32 !== 32'h0 || out_64 !== 64'h0) begin n_fail++;
            $display("FAIL reset_outs: got %h/%h want 0/0", out_32, out_64); end
        n_tests++; if (complete !== 1'b0 || wrong !== 1'b0) begin n_fail++;
            $display("FAIL reset_pulses: got %b%b want 00", complete, wrong); end
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready_after: got %b want 1", instr_ready); end
    endtask

    task automatic test_lui_ori();
        issue(enc_lui(5'd1, 16'h3F80));
        n_tests++; if (complete !== 1'b1 || wrong !== 1'b0) begin n_fail++;
            $display("FAIL lui_pulse: got c=%b w=%b want c=1 w=0", complete, wrong); end
        n_tests++; if (out_32 !== 32'h3F80_0000) begin n_fail++;
            $display("FAIL lui_out: got %h want 3f800000", out_32); end
        tick();
        n_tests++; if (complete !== 1'b0) begin n_fail++;
            $display("FAIL lui_pulse_end: got %b want 0", complete); end
        issue(enc_lui(5'd2, 16'h4000));
        issue(enc_lui(5'd0, 16'h1234));
        issue(enc_ori(5'd6, 5'd1, 16'h0001));
        issue(enc_ori(5'd7, 5'd6, 16'h0010));
        n_tests++; if (out_32 !== 32'h3F80_0011 || complete !== 1'b1) begin n_fail++;
            $display("FAIL ori_back_to_back: got %h c=%b want 3f800011 c=1", out_32, complete); end
        issue(enc_ori(5'd8, 5'd0, 16'h0000));
        n_tests++; if (out_32 !== 32'h1234_0000) begin n_fail++;
            $display("FAIL r0_not_hardwired: got %h want 12340000", out_32); end
        issue(enc_ori(5'd31, 5'd2, 16'h0000));
        n_tests++; if (out_32 !== 32'h4000_0000) begin n_fail++;
            $display("FAIL read_r2: got %h want 40000000", out_32); end
        tick();
    endtask

    task automatic test_add_s();
        issue(enc_ar(5'h10, 5'd1, 5'd2, 5'd3, 6'd0));
        n_tests++; if (unit_en !== 16'h0001) begin n_fail++;
            $display("FAIL add_s_en_c1: got %h want 0001", unit_en); end
        n_tests++; if (unit_a !== 64'h0000_0000_3F80_0000) begin n_fail++;
            $display("FAIL add_s_a: got %h want 000000003f800000", unit_a); end
        n_tests++; if (unit_b !== 64'h0000_0000_4000_0000) begin n_fail++;
            $display("FAIL add_s_b: got %h want 0000000040000000", unit_b); end
        // Other units' done flags and a new instruction must both be ignored.
        unit_complete = 16'hFFFE;
        instruction = enc_lui(5'd1, 16'hFFFF);
        instr_valid = 1'b1;
        tick();
        n_tests++; if (unit_en !== 16'h0001 || complete !== 1'b0 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_s_c2: got en=%h c=%b rdy=%b want 0001 0 0", unit_en, complete,
                     instr_ready); end
        unit_complete = 16'h0; instr_valid = 1'b0;
        tick();
        n_tests++; if (unit_en !== 16'h0001) begin n_fail++;
            $display("FAIL add_s_en_c3: got %h want 0001", unit_en); end
        unit_complete = 16'h0001; unit_z = 64'hDEAD_BEEF_4040_0000;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (unit_en !== 16'h0 || complete !== 1'b1 || wrong !== 1'b0) begin
            n_fail++;
            $display("FAIL add_s_done: got en=%h c=%b w=%b want 0000 1 0", unit_en, complete,
                     wrong); end
        n_tests++; if (out_32 !== 32'h4040_0000 || out_64 !== 64'h0) begin n_fail++;
            $display("FAIL add_s_out: got %h/%h want 40400000/0", out_32, out_64); end
        tick();
        n_tests++; if (complete !== 1'b0 || instr_ready !== 1'b1) begin n_fail++;
            $display("FAIL add_s_after: got c=%b rdy=%b want 0 1", complete, instr_ready); end
        issue(enc_ori(5'd31, 5'd3, 16'h0000));
        n_tests++; if (out_32 !== 32'h4040_0000) begin n_fail++;
            $display("FAIL add_s_wb_r3: got %h want 40400000", out_32); end
    endtask

    task automatic test_sub_s();
        issue(enc_ar(5'h10, 5'd1, 5'd2, 5'd9, 6'd1));
        n_tests++; if (unit_en !== 16'h0004) begin n_fail++;
            $display("FAIL sub_s_en: got %h want 0004", unit_en); end
        n_tests++; if (unit_a !== 64'h0000_0000_3F80_0000) begin n_fail++;
            $display("FAIL sub_s_a: got %h want 000000003f800000", unit_a); end
        n_tests++; if (unit_b !== 64'h0000_0000_C000_0000) begin n_fail++;
            $display("FAIL sub_s_b: got %h want 00000000c0000000", unit_b); end
        unit_complete = 16'h0004; unit_z = 64'h0000_0000_BF80_0000;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (complete !== 1'b1 || out_32 !== 32'hBF80_0000) begin n_fail++;
            $display("FAIL sub_s_done: got c=%b %h want 1 bf800000", complete, out_32); end
    endtask

    task automatic test_double();
        issue(enc_lui(5'd4, 16'h0123));
        issue(enc_lui(5'd20, 16'h4000));
        issue(enc_ar(5'h01, 5'd20, 5'd20, 5'd21, 6'd0));
        n_tests++; if (unit_en !== 16'h0002) begin n_fail++;
            $display("FAIL add_d_en: got %h want 0002", unit_en); end
        n_tests++; if (unit_a !== 64'h4000_0000_0123_0000 || unit_b !== 64'h4000_0000_0123_0000)
        begin n_fail++;
            $display("FAIL add_d_ops: got %h/%h want 4000000001230000 x2", unit_a, unit_b); end
        unit_complete = 16'h0002; unit_z = 64'h4010_0000_0000_0001;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (complete !== 1'b1 || out_64 !== 64'h4010_0000_0000_0001) begin n_fail++;
            $display("FAIL add_d_out64: got c=%b %h want 1 4010000000000001", complete,
                     out_64); end
        n_tests++; if (out_32 !== 32'h4000_0000) begin n_fail++;
            $display("FAIL add_d_out32_kept: got %h want 40000000", out_32); end
        issue(enc_ori(5'd31, 5'd21, 16'h0000));
        n_tests++; if (out_32 !== 32'h4010_0000) begin n_fail++;
            $display("FAIL add_d_wb_r21: got %h want 40100000", out_32); end
        issue(enc_ori(5'd31, 5'd5, 16'h0000));
        n_tests++; if (out_32 !== 32'h0000_0001) begin n_fail++;
            $display("FAIL add_d_wb_r5: got %h want 00000001", out_32); end
        issue(enc_ar(5'h01, 5'd20, 5'd21, 5'd22, 6'd1));
        n_tests++; if (unit_en !== 16'h0008 || unit_b !== 64'hC010_0000_0000_0001) begin
            n_fail++;
            $display("FAIL sub_d: got en=%h b=%h want 0008 c010000000000001", unit_en, unit_b);
        end
        unit_complete = 16'h0008; unit_z = 64'h1;
        tick();
        unit_complete = 16'h0;
        // FTOD with a junk format: format is ignored for conversions.
        issue(enc_ar(5'h07, 5'd0, 5'd1, 5'd12, 6'd6));
        n_tests++; if (unit_en !== 16'h0200 || unit_a !== 64'h3F80_0000 || unit_b !== 64'h0)
        begin n_fail++;
            $display("FAIL ftod_issue: got en=%h a=%h b=%h want 0200 3f800000 0", unit_en,
                     unit_a, unit_b); end
        unit_complete = 16'h0200; unit_z = 64'h3FF0_0000_0000_0000;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (out_64 !== 64'h3FF0_0000_0000_0000) begin n_fail++;
            $display("FAIL ftod_out64: got %h want 3ff0000000000000", out_64); end
        issue(enc_ori(5'd31, 5'd28, 16'h0000));
        n_tests++; if (out_32 !== 32'h0) begin n_fail++;
            $display("FAIL ftod_wb_r28: got %h want 0", out_32); end
        issue(enc_ar(5'h10, 5'd0, 5'd20, 5'd13, 6'd3));
        n_tests++; if (unit_en !== 16'h0040 || unit_a !== 64'h4000_0000_0123_0000) begin
            n_fail++;
            $display("FAIL dtof_issue: got en=%h a=%h want 0040 4000000001230000", unit_en,
                     unit_a); end
        unit_complete = 16'h0040; unit_z = 64'h0000_0000_3F00_0000;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (out_32 !== 32'h3F00_0000 || out_64 !== 64'h3FF0_0000_0000_0000) begin
            n_fail++;
            $display("FAIL dtof_out: got %h/%h want 3f000000/3ff0000000000000", out_32,
                     out_64); end
    endtask

    task automatic test_reject();
        issue(enc_ar(5'h05, 5'd1, 5'd2, 5'd3, 6'd0));
        n_tests++; if (wrong !== 1'b1 || complete !== 1'b0 || unit_en !== 16'h0) begin
            n_fail++;
            $display("FAIL rej_fmt: got w=%b c=%b en=%h want 1 0 0000", wrong, complete,
                     unit_en); end
        n_tests++; if (instr_ready !== 1'b1 || out_32 !== 32'h3F00_0000) begin n_fail++;
            $display("FAIL rej_fmt_state: got rdy=%b %h want 1 3f000000", instr_ready,
                     out_32); end
        tick();
        n_tests++; if (wrong !== 1'b0) begin n_fail++;
            $display("FAIL rej_pulse_end: got %b want 0", wrong); end
        issue(32'hFC00_0000);
        n_tests++; if (wrong !== 1'b1 || unit_en !== 16'h0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rej_opcode: got w=%b en=%h rdy=%b want 1 0000 1", wrong, unit_en,
                     instr_ready); end
        issue(enc_ar(5'h10, 5'd1, 5'd2, 5'd3, 6'd13));
        n_tests++; if (wrong !== 1'b1 || unit_en !== 16'h0) begin n_fail++;
            $display("FAIL rej_op: got w=%b en=%h want 1 0000", wrong, unit_en); end
        tick();
        n_tests++; if (wrong !== 1'b0 || out_64 !== 64'h3FF0_0000_0000_0000) begin n_fail++;
            $display("FAIL rej_after: got w=%b %h want 0 3ff0000000000000", wrong, out_64); end
    endtask

    task automatic test_reset_mid_exec();
        issue(enc_ar(5'h10, 5'd1, 5'd2, 5'd1, 6'd0));
        n_tests++; if (unit_en !== 16'h0001) begin n_fail++;
            $display("FAIL rst_exec_en: got %h want 0001", unit_en); end
        rst = 1'b1; unit_complete = 16'h0001; unit_z = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        n_tests++; if (unit_en !== 16'h0 || complete !== 1'b0 || wrong !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_ctl: got en=%h c=%b w=%b want 0000 0 0", unit_en, complete,
                     wrong); end
        n_tests++; if (out_32 !== 32'h0 || out_64 !== 64'h0) begin n_fail++;
            $display("FAIL rst_exec_outs: got %h/%h want 0/0", out_32, out_64); end
        rst = 1'b0; unit_complete = 16'h0;
        issue(enc_ori(5'd31, 5'd1, 16'h0000));
        n_tests++; if (out_32 !== 32'h0 || complete !== 1'b1) begin n_fail++;
            $display("FAIL rst_exec_r1: got %h c=%b want 0 1", out_32, complete); end
        issue(enc_ori(5'd31, 5'd20, 16'h0000));
        n_tests++; if (out_32 !== 32'h0) begin n_fail++;
            $display("FAIL rst_exec_r20: got %h want 0", out_32); end
    endtask

    task automatic test_timeout();
        issue(enc_ar(5'h10, 5'd1, 5'd2, 5'd3, 6'd0));
`ifdef FPU_CTRL_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            n_tests++; if (unit_en !== 16'h0001 || wrong !== 1'b0) begin n_fail++;
                $display("FAIL timeout_wait c%0d: got en=%h w=%b want 0001 0", c, unit_en,
                         wrong); end
            tick();
        end
        n_tests++; if (wrong !== 1'b1 || unit_en !== 16'h0 || complete !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: got w=%b en=%h c=%b want 1 0000 0", wrong, unit_en,
                     complete); end
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
            $display("FAIL timeout_idle: got %b want 1", instr_ready); end
        tick();
        n_tests++; if (wrong !== 1'b0) begin n_fail++;
            $display("FAIL timeout_pulse_end: got %b want 0", wrong); end
`else
        repeat (100) tick();
        n_tests++; if (unit_en !== 16'h0001 || wrong !== 1'b0 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: got en=%h w=%b rdy=%b want 0001 0 0", unit_en,
                     wrong, instr_ready); end
        unit_complete = 16'h0001; unit_z = 64'h0;
        tick();
        unit_complete = 16'h0;
        n_tests++; if (complete !== 1'b1 || unit_en !== 16'h0) begin n_fail++;
            $display("FAIL no_timeout_done: got c=%b en=%h want 1 0000", complete, unit_en); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lui_ori();
        test_add_s();
        test_sub_s();
        test_double();
        test_reject();
        test_reset_mid_exec();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
